// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the two-channel PWM configuration block: register offsets,
// channel stride, reset values, the bus FSM encoding and the per-channel config record.
package pwm_ctrl_pkg;

  localparam logic [4:0] OFF_MODE       = 5'h00;
  localparam logic [4:0] OFF_PERIOD     = 5'h04;
  localparam logic [4:0] OFF_THRESHOLD1 = 5'h08;
  localparam logic [4:0] OFF_THRESHOLD2 = 5'h0C;
  localparam logic [4:0] OFF_STEP       = 5'h10;
  localparam logic [4:0] OFF_STATUS     = 5'h14;
  localparam logic [4:0] OFF_COMMIT     = 5'h18;
  localparam logic [4:0] OFF_RSVD       = 5'h1C;

  localparam logic [31:0] CHAN_STRIDE  = 32'h20;
  localparam logic [31:0] WINDOW_BYTES = 32'h40;

  localparam logic [1:0]  RST_MODE      = 2'd0;
  localparam logic [31:0] RST_PERIOD    = 32'd1;
  localparam logic [31:0] RST_THRESHOLD = 32'd0;
  localparam logic [11:0] RST_STEP      = 12'd0;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] period;
    logic [31:0] threshold1;
    logic [31:0] threshold2;
    logic [11:0] step;
  } chan_cfg_t;

  localparam chan_cfg_t CFG_RST = '{
    mode:       RST_MODE,
    period:     RST_PERIOD,
    threshold1: RST_THRESHOLD,
    threshold2: RST_THRESHOLD,
    step:       RST_STEP
  };

endpackage

// File: rtl/pwm_ctrl_chan.sv
// One PWM channel: shadow and active config, commit pending flag and (with
// PWM_CTRL_IRQ_EN defined) the sticky done flag.
module pwm_ctrl_chan
  import pwm_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  input  logic        wrap_i,
  output chan_cfg_t   shadow_o,
  output chan_cfg_t   active_o,
  output logic        pending_o,
  output logic        done_o
);

  chan_cfg_t shadow_q, shadow_d;
  chan_cfg_t active_q, active_d;
  logic      pending_q, pending_d;
  logic      copy;

  // The copy reads shadow_q, so a write in the same cycle lands in shadow only.
  always_comb begin
    copy      = pending_q && (wrap_i || (active_q.mode == 2'd0));
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (copy) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wr_en_i) begin
      case (wr_off_i)
        OFF_MODE:       shadow_d.mode       = wdata_i[1:0];
        OFF_PERIOD:     shadow_d.period     = wdata_i;
        OFF_THRESHOLD1: shadow_d.threshold1 = wdata_i;
        OFF_THRESHOLD2: shadow_d.threshold2 = wdata_i;
        OFF_STEP:       shadow_d.step       = wdata_i[11:0];
        OFF_COMMIT:     if (wdata_i[0] && !pending_q) pending_d = 1'b1;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      shadow_q  <= CFG_RST;
      active_q  <= CFG_RST;
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

`ifdef PWM_CTRL_IRQ_EN
  logic done_q, done_d;

  // Set wins over a clear arriving in the same cycle.
  always_comb begin
    done_d = done_q;
    if (wr_en_i && (wr_off_i == OFF_STATUS) && wdata_i[1]) done_d = 1'b0;
    if (copy) done_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign done_o = done_q;
`else
  assign done_o = 1'b0;
`endif

  assign shadow_o  = shadow_q;
  assign active_o  = active_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/pwm_ctrl.sv
// Two-channel PWM register block: address decode, one-deep request/response bus FSM
// and two pwm_ctrl_chan instances. Optional done/irq logic under PWM_CTRL_IRQ_EN.
module pwm_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  input  logic [1:0]  pwm_wrap_i,
  output logic [1:0]  ch0_mode_o,
  output logic [31:0] ch0_period_o,
  output logic [31:0] ch0_threshold1_o,
  output logic [31:0] ch0_threshold2_o,
  output logic [11:0] ch0_step_o,
  output logic [1:0]  ch1_mode_o,
  output logic [31:0] ch1_period_o,
  output logic [31:0] ch1_threshold1_o,
  output logic [31:0] ch1_threshold2_o,
  output logic [11:0] ch1_step_o,
  output logic        irq_o,
  output bus_state_e  bus_state_o
);

  // Handshake: a request is accepted on a cycle where req_i && gnt_o; exactly one
  // cycle later resp_valid_o is high for one cycle with resp_rdata_o/resp_err_o.
  bus_state_e  state_q, state_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] off_full;
  logic [4:0]  reg_off;
  logic        chan_sel, accept, dec_err;
  logic [1:0]  wr_en;
  logic [31:0] rdata_d;
  chan_cfg_t   shadow_w [2];
  chan_cfg_t   active_w [2];
  chan_cfg_t   rd_cfg;
  logic [1:0]  pending_w, done_w;

  // Unsigned subtraction makes addresses below BASE_ADDR fall outside the window too.
  always_comb begin
    off_full = addr_i - BASE_ADDR;
    reg_off  = off_full[4:0];
    chan_sel = off_full[5];
    dec_err  = (off_full >= WINDOW_BYTES) || (addr_i[1:0] != 2'b00) ||
               (reg_off == OFF_RSVD) ||
               (we_i && (reg_off == OFF_PERIOD) && (wdata_i == 32'd0));
    accept   = req_i && (state_q == BUS_IDLE);
    wr_en[0] = accept && we_i && !dec_err && !chan_sel;
    wr_en[1] = accept && we_i && !dec_err && chan_sel;
    rd_cfg   = chan_sel ? shadow_w[1] : shadow_w[0];
    rdata_d  = 32'd0;
    case (reg_off)
      OFF_MODE:       rdata_d = {30'd0, rd_cfg.mode};
      OFF_PERIOD:     rdata_d = rd_cfg.period;
      OFF_THRESHOLD1: rdata_d = rd_cfg.threshold1;
      OFF_THRESHOLD2: rdata_d = rd_cfg.threshold2;
      OFF_STEP:       rdata_d = {20'd0, rd_cfg.step};
      OFF_STATUS:     rdata_d = {30'd0, done_w[chan_sel], pending_w[chan_sel]};
      default:        rdata_d = 32'd0;
    endcase
    if (dec_err || we_i) rdata_d = 32'd0;
    resp_rdata_d = accept ? rdata_d : resp_rdata_q;
    resp_err_d   = accept ? dec_err : resp_err_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (req_i) state_d = BUS_RESP;
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    gnt_o        = (state_q == BUS_IDLE);
    resp_valid_o = (state_q == BUS_RESP);
    bus_state_o  = state_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  pwm_ctrl_chan u_chan0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en[0]),
    .wr_off_i  (reg_off),
    .wdata_i   (wdata_i),
    .wrap_i    (pwm_wrap_i[0]),
    .shadow_o  (shadow_w[0]),
    .active_o  (active_w[0]),
    .pending_o (pending_w[0]),
    .done_o    (done_w[0])
  );

  pwm_ctrl_chan u_chan1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en[1]),
    .wr_off_i  (reg_off),
    .wdata_i   (wdata_i),
    .wrap_i    (pwm_wrap_i[1]),
    .shadow_o  (shadow_w[1]),
    .active_o  (active_w[1]),
    .pending_o (pending_w[1]),
    .done_o    (done_w[1])
  );

  assign ch0_mode_o       = active_w[0].mode;
  assign ch0_period_o     = active_w[0].period;
  assign ch0_threshold1_o = active_w[0].threshold1;
  assign ch0_threshold2_o = active_w[0].threshold2;
  assign ch0_step_o       = active_w[0].step;
  assign ch1_mode_o       = active_w[1].mode;
  assign ch1_period_o     = active_w[1].period;
  assign ch1_threshold1_o = active_w[1].threshold1;
  assign ch1_threshold2_o = active_w[1].threshold2;
  assign ch1_step_o       = active_w[1].step;
  assign irq_o            = done_w[0] | done_w[1];

endmodule
